quad_sample_packer: RTL and testbench

Sequences the four per-channel ADC sample streams after they have crossed into the AXI clock domain. It collects one sample from each channel into a 4-slot frame and emits the completed frame as one 64-bit AXI-Stream beat with packet framing. It discards frames with excessive inter-channel skew and reports overruns. It sits between the four channel clock-domain crossers and the DMA stream input of the quad ADC IP.

---
 rtl/quad_sample_packer.sv | 133 +++++++++++++
 tb/tb_quad_sample_packer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_sample_packer.sv
// Gathers one sample per ADC channel into a four-lane frame and streams
// each completed frame as a 64-bit AXI-Stream beat with packet framing.
module quad_sample_packer #(
   parameter int PACKET_LEN   = 1024,
   parameter int SKEW_TIMEOUT = 16
) (
   input  logic        AXI_CLK,
   input  logic        RESET_N,
   input  logic        ENABLE,
   input  logic        CLEAR_ERRORS,
   input  logic [3:0]  CH_VALID,
   input  logic [55:0] CH_DATA,
   output logic [63:0] M_TDATA,
   output logic        M_TVALID,
   input  logic        M_TREADY,
   output logic        M_TLAST,
   output logic        OVERRUN,
   output logic [15:0] DROP_COUNT
);

   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

   localparam logic [15:0] LAST_BEAT = 16'(PACKET_LEN - 1);
   localparam logic [7:0]  TMO       = 8'(SKEW_TIMEOUT);

   state_t           state_q, state_d;
   logic [3:0][13:0] slot_q, slot_d;
   logic [3:0]       full_q, full_d;
   logic [7:0]       tmr_q, tmr_d;
   logic [15:0]      cnt_q, cnt_d, cnt_step;
   logic [63:0]      tdata_d;
   logic             tvalid_d, tlast_d, ovr_d;
   logic [15:0]      drop_d;
   logic             accept, out_free, load, timeout, new_ovr;
   logic [3:0]       base_full, cap;

   assign accept   = M_TVALID & M_TREADY;
   assign out_free = ~M_TVALID | M_TREADY;
   assign load     = ENABLE & (state_q == HOLD) & out_free;
   assign timeout  = ENABLE & (state_q == COLLECT) & (tmr_q == TMO);

   // Slots emptied by a load or timeout can take a strobe on that same edge.
   assign base_full = (load | timeout) ? 4'h0 : full_q;
   assign cap       = ENABLE ? (CH_VALID & ~base_full) : 4'h0;
   assign new_ovr   = ENABLE & (|(CH_VALID & base_full));

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      full_d   = full_q;
      tmr_d    = tmr_q;
      tdata_d  = M_TDATA;
      tvalid_d = M_TVALID;
      tlast_d  = M_TLAST;
      ovr_d    = OVERRUN;
      drop_d   = DROP_COUNT;
      cnt_step = cnt_q;

      if (accept)
         cnt_step = (cnt_q == LAST_BEAT) ? 16'd0 : cnt_q + 16'd1;
      cnt_d = (~ENABLE & ~M_TVALID) ? 16'd0 : cnt_step;

      if (load) begin
         tdata_d  = {2'b00, slot_q[3], 2'b00, slot_q[2],
                     2'b00, slot_q[1], 2'b00, slot_q[0]};
         tvalid_d = 1'b1;
         tlast_d  = (cnt_step == LAST_BEAT);
      end else if (accept) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end

      for (int n = 0; n < 4; n++)
         if (cap[n])
            slot_d[n] = CH_DATA[14*n +: 14];

      if (!ENABLE) begin
         state_d = IDLE;
         full_d  = 4'h0;
         tmr_d   = 8'd0;
      end else begin
         full_d  = base_full | cap;
         state_d = (full_d == 4'hF) ? HOLD : COLLECT;
         if (load | timeout)
            tmr_d = (|cap) ? 8'd1 : 8'd0;
         else if (state_q == HOLD)
            tmr_d = tmr_q;
         else
            tmr_d = (|full_d) ? tmr_q + 8'd1 : 8'd0;
      end

      if (new_ovr)
         ovr_d = 1'b1;
      else if (CLEAR_ERRORS)
         ovr_d = 1'b0;

      if (timeout) begin
         if (CLEAR_ERRORS)
            drop_d = 16'd1;
         else if (DROP_COUNT != 16'hFFFF)
            drop_d = DROP_COUNT + 16'd1;
      end else if (CLEAR_ERRORS) begin
         drop_d = 16'd0;
      end
   end

   always_ff @(posedge AXI_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         slot_q     <= '0;
         full_q     <= 4'h0;
         tmr_q      <= 8'd0;
         cnt_q      <= 16'd0;
         M_TDATA    <= 64'd0;
         M_TVALID   <= 1'b0;
         M_TLAST    <= 1'b0;
         OVERRUN    <= 1'b0;
         DROP_COUNT <= 16'd0;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         full_q     <= full_d;
         tmr_q      <= tmr_d;
         cnt_q      <= cnt_d;
         M_TDATA    <= tdata_d;
         M_TVALID   <= tvalid_d;
         M_TLAST    <= tlast_d;
         OVERRUN    <= ovr_d;
         DROP_COUNT <= drop_d;
      end
   end

endmodule

// File: tb/tb_quad_sample_packer.sv
// Directed scenarios plus a randomized run against a frame-level
// reference model of the quad sample packer.
module tb_quad_sample_packer;

   localparam int PL  = 4;
   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        clr = 1'b0;
   logic        rdy = 1'b0;
   logic [3:0]  v = 4'h0;
   logic [55:0] d = 56'd0;
   logic [63:0] tdata;
   logic        tvalid, tlast, ovr;
   logic [15:0] drop;

   int errors = 0;
   int checks = 0;

   bit          m_full [4];
   logic [13:0] m_val [4];
   int          m_age, m_beat, m_drop;
   bit          m_tv, m_last, m_ovr;
   logic [63:0] m_data;

   quad_sample_packer #(.PACKET_LEN(PL), .SKEW_TIMEOUT(TMO)) dut (
      .AXI_CLK(clk), .RESET_N(rst_n), .ENABLE(en),
      .CLEAR_ERRORS(clr), .CH_VALID(v), .CH_DATA(d),
      .M_TDATA(tdata), .M_TVALID(tvalid), .M_TREADY(rdy),
      .M_TLAST(tlast), .OVERRUN(ovr), .DROP_COUNT(drop)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   function automatic logic [55:0] rnd_frame();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [63:0] lanes(input logic [55:0] s);
      return {2'b00, s[55:42], 2'b00, s[41:28],
              2'b00, s[27:14], 2'b00, s[13:0]};
   endfunction

   task automatic cyc(input logic [3:0] vv, input logic [55:0] dd);
      v = vv;
      d = dd;
      @(posedge clk);
      #1;
      v = 4'h0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_reset();
      for (int n = 0; n < 4; n++) begin
         m_full[n] = 0;
         m_val[n]  = 14'd0;
      end
      m_age = 0; m_beat = 0; m_drop = 0;
      m_tv = 0; m_last = 0; m_ovr = 0;
      m_data = 64'd0;
   endtask

   task automatic model_edge();
      bit complete, taken, ld, tmo, newov, any;
      int nbeat;
      complete = m_full[0] && m_full[1] && m_full[2] && m_full[3];
      taken    = m_tv && rdy;
      ld       = en && complete && (!m_tv || rdy);
      tmo      = en && !complete && (m_age >= TMO);
      nbeat    = taken ? (m_beat + 1) % PL : m_beat;
      if (!en && !m_tv) nbeat = 0;
      if (ld) begin
         m_data = {2'b00, m_val[3], 2'b00, m_val[2],
                   2'b00, m_val[1], 2'b00, m_val[0]};
         m_tv   = 1;
         m_last = (nbeat == PL - 1);
      end else if (taken) begin
         m_tv   = 0;
         m_last = 0;
      end
      m_beat = nbeat;
      newov  = 0;
      if (!en) begin
         for (int n = 0; n < 4; n++) m_full[n] = 0;
         m_age = 0;
      end else begin
         if (ld || tmo)
            for (int n = 0; n < 4; n++) m_full[n] = 0;
         for (int n = 0; n < 4; n++)
            if (v[n]) begin
               if (m_full[n]) newov = 1;
               else begin
                  m_full[n] = 1;
                  m_val[n]  = d[14*n +: 14];
               end
            end
         any = m_full[0] || m_full[1] || m_full[2] || m_full[3];
         if (ld || tmo) m_age = any ? 1 : 0;
         else if (!complete) m_age = any ? m_age + 1 : 0;
      end
      if (newov) m_ovr = 1;
      else if (clr) m_ovr = 0;
      if (tmo) m_drop = clr ? 1 : (m_drop < 65535 ? m_drop + 1 : m_drop);
      else if (clr) m_drop = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; rdy = 1'b1;
      idle(2);
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b exp 0", tvalid); end
      checks++; if (tdata !== 64'd0) begin errors++; $display("FAIL reset_tdata: got %h exp 0", tdata); end
      checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b exp 0", tlast); end
      checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b exp 0", ovr); end
      checks++; if (drop !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d exp 0", drop); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_staggered();
      en = 1'b1;
      idle(1);
      cyc(4'h1, {14'd0, 14'd0, 14'd0, 14'hABC});
      cyc(4'h2, {14'd0, 14'd0, 14'hABD, 14'd0});
      cyc(4'h4, {14'd0, 14'hABE, 14'd0, 14'd0});
      cyc(4'h8, {14'hABF, 14'd0, 14'd0, 14'd0});
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL stag_early: tvalid got %b exp 0", tvalid); end
      idle(1);
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL stag_valid: got %b exp 1", tvalid); end
      checks++; if (tdata !== 64'h0ABF_0ABE_0ABD_0ABC) begin errors++; $display("FAIL stag_data: got %h exp 0abf0abe0abd0abc", tdata); end
      checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL stag_tlast: got %b exp 0", tlast); end
      idle(1);
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL stag_single: tvalid got %b exp 0", tvalid); end
   endtask

   task automatic test_timeout();
      logic [55:0] s;
      cyc(4'h1, rnd_frame());
      cyc(4'h2, rnd_frame());
      idle(2);
      checks++; if (drop !== 16'd0) begin errors++; $display("FAIL tmo_early: drop got %0d exp 0", drop); end
      idle(1);
      checks++; if (drop !== 16'd1) begin errors++; $display("FAIL tmo_drop: got %0d exp 1", drop); end
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL tmo_nobeat: tvalid got %b exp 0", tvalid); end
      s = rnd_frame();
      cyc(4'hF, s);
      idle(1);
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL tmo_after_valid: got %b exp 1", tvalid); end
      checks++; if (tdata !== lanes(s)) begin errors++; $display("FAIL tmo_after_data: got %h exp %h", tdata, lanes(s)); end
      idle(1);
   endtask

   task automatic test_backpressure();
      logic [55:0] a, b;
      a = rnd_frame();
      b = rnd_frame();
      rdy = 1'b0;
      cyc(4'hF, a);
      idle(1);
      cyc(4'hF, b);
      idle(2);
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL bp_wait_valid: got %b exp 1", tvalid); end
      checks++; if (tdata !== lanes(a)) begin errors++; $display("FAIL bp_wait_data: got %h exp %h", tdata, lanes(a)); end
      checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL bp_no_ovr: got %b exp 0", ovr); end
      cyc(4'hF, rnd_frame());
      checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %b exp 1", ovr); end
      checks++; if (tdata !== lanes(a)) begin errors++; $display("FAIL bp_stable: got %h exp %h", tdata, lanes(a)); end
      checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL bp_tlast_a: got %b exp 0", tlast); end
      rdy = 1'b1;
      idle(1);
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL bp_second_valid: got %b exp 1", tvalid); end
      checks++; if (tdata !== lanes(b)) begin errors++; $display("FAIL bp_second_data: got %h exp %h", tdata, lanes(b)); end
      checks++; if (tlast !== 1'b1) begin errors++; $display("FAIL bp_tlast_b: got %b exp 1", tlast); end
      idle(1);
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL bp_drain: tvalid got %b exp 0", tvalid); end
   endtask

   task automatic test_clear();
      clr = 1'b1;
      idle(1);
      clr = 1'b0;
      checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL clr_ovr: got %b exp 0", ovr); end
      checks++; if (drop !== 16'd0) begin errors++; $display("FAIL clr_drop: got %0d exp 0", drop); end
      cyc(4'h4, rnd_frame());
      idle(3);
      clr = 1'b1;
      idle(1);
      clr = 1'b0;
      checks++; if (drop !== 16'd1) begin errors++; $display("FAIL clr_with_tmo: drop got %0d exp 1", drop); end
   endtask

   task automatic test_packet();
      logic [55:0] s;
      en = 1'b0;
      idle(2);
      en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         s = rnd_frame();
         cyc(4'hF, s);
         idle(1);
         checks++; if (tvalid !== 1'b1 || tdata !== lanes(s)) begin errors++; $display("FAIL pkt_beat%0d: got %b/%h exp 1/%h", i, tvalid, tdata, lanes(s)); end
         checks++; if (tlast !== (i % PL == PL - 1)) begin errors++; $display("FAIL pkt_tlast%0d: got %b exp %b", i, tlast, (i % PL == PL - 1)); end
      end
      idle(1);
      en = 1'b0;
      idle(1);
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(4'hF, rnd_frame());
         idle(1);
         checks++; if (tlast !== (i == 3)) begin errors++; $display("FAIL pkt_reen_tlast%0d: got %b exp %b", i, tlast, (i == 3)); end
      end
      idle(1);
   endtask

   task automatic test_reset_mid();
      logic [55:0] s;
      rdy = 1'b0;
      cyc(4'hF, rnd_frame());
      idle(1);
      cyc(4'h3, rnd_frame());
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rmid_tvalid: got %b exp 0", tvalid); end
      checks++; if (tdata !== 64'd0) begin errors++; $display("FAIL rmid_tdata: got %h exp 0", tdata); end
      checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL rmid_tlast: got %b exp 0", tlast); end
      checks++; if (drop !== 16'd0) begin errors++; $display("FAIL rmid_drop: got %0d exp 0", drop); end
      @(negedge clk);
      rst_n = 1'b1;
      rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s = rnd_frame();
         cyc(4'hF, s);
         idle(1);
         checks++; if (tvalid !== 1'b1 || tdata !== lanes(s)) begin errors++; $display("FAIL rmid_beat%0d: got %b/%h exp 1/%h", i, tvalid, tdata, lanes(s)); end
         checks++; if (tlast !== (i == 3)) begin errors++; $display("FAIL rmid_tlast%0d: got %b exp %b", i, tlast, (i == 3)); end
      end
      idle(1);
   endtask

   task automatic test_random();
      rst_n = 1'b0;
      en = 1'b0; clr = 1'b0; v = 4'h0; rdy = 1'b0;
      idle(1);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         en  = ($urandom % 40) != 0;
         clr = ($urandom % 64) == 0;
         rdy = ($urandom % 4) != 0;
         for (int n = 0; n < 4; n++) v[n] = ($urandom % 4) == 0;
         d = rnd_frame();
         @(posedge clk);
         model_edge();
         #1;
         checks++; if (tvalid !== m_tv) begin errors++; $display("FAIL rnd_tvalid c%0d: got %b exp %b", c, tvalid, m_tv); end
         if (m_tv) begin
            checks++; if (tdata !== m_data) begin errors++; $display("FAIL rnd_tdata c%0d: got %h exp %h", c, tdata, m_data); end
            checks++; if (tlast !== m_last) begin errors++; $display("FAIL rnd_tlast c%0d: got %b exp %b", c, tlast, m_last); end
         end
         checks++; if (ovr !== m_ovr) begin errors++; $display("FAIL rnd_overrun c%0d: got %b exp %b", c, ovr, m_ovr); end
         checks++; if (drop !== 16'(m_drop)) begin errors++; $display("FAIL rnd_drop c%0d: got %0d exp %0d", c, drop, m_drop); end
      end
   endtask

   initial begin
      test_reset();
      test_staggered();
      test_timeout();
      test_backpressure();
      test_clear();
      test_packet();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
